pk_fnkeys: RTL and testbench

Parametrised successor to the control-panel virtual-switch logic. It decodes panel command bytes received over the serial link into NKEYS function-key outputs. Each key has its own compile-time mode: level, one-cycle pulse, toggle, or level gated by a per-key enable. It also carries the rotary switch position and the LED-report request, and sits between the UART receiver and the CPU control signals.

---
 rtl/pk_fnkeys_pkg.sv | 48 ++++
 rtl/pk_fnkeys_if.sv | 8 +
 rtl/pk_fnkey_cell.sv | 51 +++++
 rtl/pk_fnkeys.sv | 90 +++++++++
 tb/tb_pk_fnkeys.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/pk_fnkeys_pkg.sv
// Shared constants for the function-key panel decoder: key modes, command
// fields, key indices and the command classifier.
package pk_pkg;

    typedef enum logic [1:0] {
        KM_LEVEL  = 2'd0,
        KM_PULSE  = 2'd1,
        KM_TOGGLE = 2'd2,
        KM_GATED  = 2'd3
    } key_mode_e;

    typedef enum logic [1:0] {
        DEC_KEY,
        DEC_ROT,
        DEC_REPORT,
        DEC_BAD
    } dec_e;

    localparam logic [1:0] CMD_KEY    = 2'b10;
    localparam logic [3:0] CMD_ROT    = 4'b0100;
    localparam logic [7:0] CMD_REPORT = 8'hC0;

    localparam int FN_START   = 0;
    localparam int FN_STOP    = 1;
    localparam int FN_CONT    = 2;
    localparam int FN_STEP    = 3;
    localparam int FN_SSTEP   = 4;
    localparam int FN_EXAM    = 5;
    localparam int FN_EXNEXT  = 6;
    localparam int FN_DEP     = 7;
    localparam int FN_DEPNEXT = 8;
    localparam int FN_LOAD    = 9;
    localparam int FN_RESET   = 10;
    localparam int FN_CLEAR   = 11;

    // Key bytes addressing a key beyond the configured count are protocol errors.
    function automatic dec_e decode_cmd(input logic [7:0] b, input int unsigned nkeys);
        if (b[7:6] == CMD_KEY && 32'(b[4:0]) < nkeys)
            return DEC_KEY;
        else if (b[7:4] == CMD_ROT)
            return DEC_ROT;
        else if (b == CMD_REPORT)
            return DEC_REPORT;
        else
            return DEC_BAD;
    endfunction

endpackage

// File: rtl/pk_fnkeys_if.sv
// Byte link from the UART receiver into the function-key decoder.
interface pk_fnkeys_if;
    logic       rx_valid;
    logic [7:0] rx_byte;

    modport master (output rx_valid, output rx_byte);
    modport slave  (input  rx_valid, input  rx_byte);
endinterface

// File: rtl/pk_fnkey_cell.sv
// One function key: raw pressed state plus a mode-dependent output flop
// (level copy, edge pulse, toggle, or gated level).
module pk_fnkey_cell
    import pk_pkg::*;
#(
    parameter logic [1:0] MODE = KM_LEVEL
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic ev,
    input  logic v,
    input  logic gate,
    input  logic clr,
    input  logic wdt_rel,
    output logic key
);

    logic s_q;
    logic s_nxt;
    logic key_nxt;
    logic rise;

    // In toggle mode key itself is the toggle flop; clr beats a coincident press.
    always_comb begin
        s_nxt   = s_q;
        key_nxt = key;
        rise    = ev & v & ~s_q;
        if (ev)
            s_nxt = v;
        else if (wdt_rel && (MODE == KM_LEVEL || MODE == KM_GATED))
            s_nxt = 1'b0;
        case (MODE)
            KM_LEVEL:  key_nxt = s_nxt;
            KM_PULSE:  key_nxt = rise;
            KM_TOGGLE: key_nxt = clr ? 1'b0 : (key ^ rise);
            KM_GATED:  key_nxt = s_nxt & gate;
            default:   key_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            s_q <= 1'b0;
            key <= 1'b0;
        end else begin
            s_q <= s_nxt;
            key <= key_nxt;
        end
    end

endmodule

// File: rtl/pk_fnkeys.sv
// Panel command decoder: bytes from the serial link drive NKEYS function keys,
// the rotary position and LED-report requests. Link watchdog: PK_FNKEYS_LINK_WDT_EN.
module pk_fnkeys
    import pk_pkg::*;
#(
    parameter int unsigned          NKEYS        = 12,
    parameter logic [2*NKEYS-1:0]   KEY_MODE     = '0,
    parameter int unsigned          LINK_TIMEOUT = 50000000
) (
    input  logic             clk_sys,
    input  logic             rst_n,
    pk_fnkeys_if.slave       rx,
    input  logic [NKEYS-1:0] gate,
    input  logic             clr,
    output logic [NKEYS-1:0] keys,
    output logic [3:0]       rotary_pos,
    output logic             send_leds,
    output logic             proto_err,
    output logic             link_up
);

    dec_e       dec;
    logic [4:0] key_idx;
    logic       key_val;
    logic       wdt_rel;

    assign dec     = decode_cmd(rx.rx_byte, NKEYS);
    assign key_idx = rx.rx_byte[4:0];
    assign key_val = rx.rx_byte[5];

    for (genvar i = 0; i < NKEYS; i++) begin : g_key
        logic ev;
        assign ev = rx.rx_valid && (dec == DEC_KEY) && (key_idx == 5'(i));

        pk_fnkey_cell #(.MODE(KEY_MODE[2*i +: 2])) u_cell (
            .clk_sys (clk_sys),
            .rst_n   (rst_n),
            .ev      (ev),
            .v       (key_val),
            .gate    (gate[i]),
            .clr     (clr),
            .wdt_rel (wdt_rel),
            .key     (keys[i])
        );
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            rotary_pos <= 4'd0;
            send_leds  <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            send_leds <= rx.rx_valid && (dec == DEC_REPORT);
            proto_err <= rx.rx_valid && (dec == DEC_BAD);
            if (rx.rx_valid && dec == DEC_ROT)
                rotary_pos <= rx.rx_byte[3:0];
        end
    end

`ifdef PK_FNKEYS_LINK_WDT_EN
    localparam int CW = $clog2(LINK_TIMEOUT + 1);

    logic [CW-1:0] wdt_cnt;
    logic          wdt_full;

    // A byte arriving on the timeout cycle keeps the link up and is applied.
    assign wdt_full = (wdt_cnt == CW'(LINK_TIMEOUT));
    assign wdt_rel  = wdt_full & ~rx.rx_valid;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            wdt_cnt <= '0;
            link_up <= 1'b1;
        end else begin
            if (rx.rx_valid)
                wdt_cnt <= '0;
            else if (!wdt_full)
                wdt_cnt <= wdt_cnt + 1'b1;
            if (rx.rx_valid)
                link_up <= 1'b1;
            else if (wdt_full)
                link_up <= 1'b0;
        end
    end
`else
    assign wdt_rel = 1'b0;
    assign link_up = 1'b1;
`endif

endmodule

// File: tb/tb_pk_fnkeys.sv
// Self-checking bench for pk_fnkeys: directed literal checks, then random bytes
// against a behavioural model of the key/rotary/report rules.
module tb_pk_fnkeys;

    localparam int NK = 12;
    // key modes 0..11: 0,1,2,2,1,3,0,3,2,1,0,3
    localparam logic [2*NK-1:0] TB_MODE = {2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0,
                                           2'd3, 2'd1, 2'd2, 2'd2, 2'd1, 2'd0};
`ifdef PK_FNKEYS_LINK_WDT_EN
    localparam int LT = 100;
`else
    localparam int LT = 50000000;
`endif

    logic          clk_sys = 1'b0;
    logic          rst_n   = 1'b0;
    logic [NK-1:0] gate    = '0;
    logic          clr     = 1'b0;
    logic [NK-1:0] keys;
    logic [3:0]    rotary_pos;
    logic          send_leds;
    logic          proto_err;
    logic          link_up;

    int n_checks = 0;
    int n_pass   = 0;

    pk_fnkeys_if u_if ();

    pk_fnkeys #(.NKEYS(NK), .KEY_MODE(TB_MODE), .LINK_TIMEOUT(LT)) dut (
        .clk_sys    (clk_sys),
        .rst_n      (rst_n),
        .rx         (u_if.slave),
        .gate       (gate),
        .clr        (clr),
        .keys       (keys),
        .rotary_pos (rotary_pos),
        .send_leds  (send_leds),
        .proto_err  (proto_err),
        .link_up    (link_up)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural model: pressed state, toggle state and expected outputs.
    bit          m_s   [NK];
    bit          m_tog [NK];
    bit          m_pls [NK];
    logic [NK-1:0] e_keys;
    int          e_rot;
    bit          e_send, e_err, e_link;
    int          idle;

    function automatic int mode_of(input int i);
        return int'((TB_MODE >> (2 * i)) & 3);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NK; i++) begin
            m_s[i] = 0; m_tog[i] = 0; m_pls[i] = 0;
        end
        e_keys = '0; e_rot = 0; e_send = 0; e_err = 0; e_link = 1; idle = 0;
    endtask

    task automatic model_step();
        int b, k;
        bit v, rise;
        e_send = 0;
        e_err  = 0;
        for (int i = 0; i < NK; i++) m_pls[i] = 0;
        if (u_if.rx_valid) begin
            b = int'(u_if.rx_byte);
            if (b / 64 == 2 && b % 32 < NK) begin
                k = b % 32;
                v = ((b / 32) % 2) == 1;
                rise = !m_s[k] && v;
                m_s[k] = v;
                if (mode_of(k) == 1) m_pls[k] = rise;
                if (mode_of(k) == 2 && rise) m_tog[k] = !m_tog[k];
            end else if (b / 16 == 4) begin
                e_rot = b % 16;
            end else if (b == 192) begin
                e_send = 1;
            end else begin
                e_err = 1;
            end
        end
        if (clr)
            for (int i = 0; i < NK; i++) m_tog[i] = 0;
`ifdef PK_FNKEYS_LINK_WDT_EN
        if (u_if.rx_valid) begin
            idle = 0; e_link = 1;
        end else if (idle == LT) begin
            e_link = 0;
            for (int i = 0; i < NK; i++)
                if (mode_of(i) == 0 || mode_of(i) == 3) m_s[i] = 0;
        end else begin
            idle++;
        end
`endif
        for (int i = 0; i < NK; i++) begin
            case (mode_of(i))
                0: e_keys[i] = m_s[i];
                1: e_keys[i] = m_pls[i];
                2: e_keys[i] = m_tog[i];
                default: e_keys[i] = m_s[i] && gate[i];
            endcase
        end
    endtask

    always @(posedge clk_sys) begin
        if (!rst_n) model_reset();
        else        model_step();
        #1;
        check("keys", 32'(keys), 32'(e_keys));
        check("rotary_pos", 32'(rotary_pos), 32'(e_rot));
        check("send_leds", 32'(send_leds), 32'(e_send));
        check("proto_err", 32'(proto_err), 32'(e_err));
        check("link_up", 32'(link_up), 32'(e_link));
    end

    // One clock: drive the byte link at negedge, return 2 units after posedge.
    task automatic cyc(input logic v, input logic [7:0] b);
        @(negedge clk_sys);
        u_if.rx_valid = v;
        u_if.rx_byte  = b;
        @(posedge clk_sys);
        #2;
    endtask

    initial begin
        logic [7:0] rb;
        int r;
        u_if.rx_valid = 1'b0;
        u_if.rx_byte  = 8'h00;
        repeat (2) @(posedge clk_sys);
        #2;
        check("reset keys", 32'(keys), 0);
        check("reset link_up", 32'(link_up), 1);
        @(negedge clk_sys);
        rst_n = 1'b1;

        cyc(1, 8'hA0); check("lvl press", 32'(keys[0]), 1);
        cyc(0, 8'h00); check("lvl hold", 32'(keys[0]), 1);
        cyc(1, 8'h80); check("lvl release", 32'(keys[0]), 0);

        cyc(1, 8'hA4); check("pulse 1", 32'(keys[4]), 1);
        cyc(0, 8'h00); check("pulse 1 end", 32'(keys[4]), 0);
        cyc(1, 8'hA4); check("pulse repeat", 32'(keys[4]), 0);
        cyc(1, 8'h84); check("pulse release", 32'(keys[4]), 0);
        cyc(1, 8'hA4); check("pulse 2", 32'(keys[4]), 1);
        cyc(0, 8'h00); check("pulse 2 end", 32'(keys[4]), 0);

        cyc(1, 8'hA3); check("tog on", 32'(keys[3]), 1);
        cyc(1, 8'h83); check("tog rel", 32'(keys[3]), 1);
        cyc(1, 8'hA3); check("tog off", 32'(keys[3]), 0);
        cyc(1, 8'h83); check("tog rel2", 32'(keys[3]), 0);
        clr = 1'b1;
        cyc(1, 8'hA3); check("tog clr wins", 32'(keys[3]), 0);
        clr = 1'b0;
        cyc(0, 8'h00); check("tog consumed", 32'(keys[3]), 0);

        cyc(1, 8'hA5); check("gated off", 32'(keys[5]), 0);
        gate[5] = 1'b1;
        cyc(0, 8'h00); check("gated on", 32'(keys[5]), 1);

        cyc(1, 8'h47); check("rotary", 32'(rotary_pos), 7);
        cyc(1, 8'hC0); check("report", 32'(send_leds), 1);
        cyc(1, 8'hBF); check("report end", 32'(send_leds), 0);
        check("err key>=N", 32'(proto_err), 1);
        cyc(1, 8'h13); check("err junk", 32'(proto_err), 1);
        check("rotary kept", 32'(rotary_pos), 7);
        cyc(0, 8'h00); check("err end", 32'(proto_err), 0);

`ifdef PK_FNKEYS_LINK_WDT_EN
        cyc(1, 8'h83);
        cyc(1, 8'hA3);
        cyc(1, 8'hA0);
        repeat (100) cyc(0, 8'h00);
        check("wdt link before", 32'(link_up), 1);
        check("wdt key0 before", 32'(keys[0]), 1);
        cyc(0, 8'h00);
        check("wdt link down", 32'(link_up), 0);
        check("wdt key0 released", 32'(keys[0]), 0);
        check("wdt tog kept", 32'(keys[3]), 1);
        check("wdt rotary kept", 32'(rotary_pos), 7);
        cyc(1, 8'h13);
        check("wdt link back", 32'(link_up), 1);
`endif

        for (int n = 0; n < 3000; n++) begin
            gate = NK'($urandom);
            clr  = ($urandom_range(0, 7) == 0);
            r = $urandom_range(0, 9);
            if (r < 5)       rb = {2'b10, 1'($urandom), 5'($urandom_range(0, 13))};
            else if (r == 5) rb = {4'b0100, 4'($urandom)};
            else if (r == 6) rb = 8'hC0;
            else             rb = 8'($urandom);
            cyc(($urandom_range(0, 2) != 0), rb);
        end
        clr = 1'b0;
        cyc(0, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
